// File: rtl/io_responder.sv
// -----------------------------------------------------------------------------
// io_responder
//
// Memory-mapped board I/O block for a small CPU.
//   - Four 32-bit registers are selected by io_sel:
//       0 SW  : debounced switches, zero-extended (read-only)
//       1 LED : low 16 bits drive the LEDs (read/write)
//       2 SEG : eight hex digits for the seven-segment display (read/write)
//       3 BTN : bit 0 is a sticky "button pressed" flag (read-only;
//               a read clears it)
//   - Loads are combinational, so there is no wait state.
//   - Stores update the register at the same rising edge.
//   - Switches and the button each pass through a two-flop synchronizer and
//     then a saturating debounce counter.
//   - A free-running prescaler multiplexes the eight display digits.
//
// Ports
//   clk       system clock; all state changes on its rising edge
//   rst       synchronous active-high reset
//   IoRead    load strobe; one cycle per load
//   IoWrite   store strobe; one cycle per store
//   io_sel    register select (ALU result bits [23:22])
//   io_wdata  store data
//   io_rdata  load data; zero whenever IoRead is low
//   sw_in     raw switches (asynchronous)
//   btn_in    raw button, active-high (asynchronous)
//   led_out   LED drive, active-high
//   seg_an    digit enables, active-low, one digit at a time
//   seg_out   segments {dp,g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module io_responder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_DIV        = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IoRead,
  input  logic        IoWrite,
  input  logic [1:0]  io_sel,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  input  logic [15:0] sw_in,
  input  logic        btn_in,
  output logic [15:0] led_out,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);

  // Counter widths are kept at least one bit wide so that degenerate
  // parameter values (1) still elaborate.
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_DIV - 1);

  localparam logic [1:0] SEL_SW  = 2'd0;
  localparam logic [1:0] SEL_LED = 2'd1;
  localparam logic [1:0] SEL_SEG = 2'd2;
  localparam logic [1:0] SEL_BTN = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [15:0]   led_reg,       led_next;
  logic [31:0]   seg_reg,       seg_next;
  logic          pending_reg,   pending_next;

  logic [15:0]   sw_meta_reg,   sw_sync_reg;
  logic [15:0]   sw_stable_reg, sw_stable_next;
  logic [DW-1:0] sw_cnt_reg,    sw_cnt_next;

  logic          btn_meta_reg,  btn_sync_reg;
  logic          btn_stable_reg, btn_stable_next;
  logic [DW-1:0] btn_cnt_reg,   btn_cnt_next;

  logic [PW-1:0] presc_reg,     presc_next;
  logic [2:0]    digit_reg,     digit_next;

  // ---------------------------------------------------------------------------
  // Debounce
  // While the synchronized value matches the accepted value, the counter
  // sits at zero. Otherwise it counts up one step per cycle. When it has
  // reached DEBOUNCE_CYCLES-1 and the input still differs, the new value is
  // accepted. The counter never wraps. A glitch shorter than the window lets
  // the synchronized value fall back to the accepted value, which zeroes the
  // counter again.
  // ---------------------------------------------------------------------------
  logic sw_differs, sw_accept;
  logic btn_differs, btn_accept, btn_press;

  always_comb begin
    sw_differs     = (sw_sync_reg != sw_stable_reg);
    sw_accept      = sw_differs && (sw_cnt_reg == DB_LAST);
    sw_stable_next = sw_stable_reg;
    sw_cnt_next    = sw_cnt_reg;
    if (!sw_differs) begin
      sw_cnt_next = '0;
    end else if (sw_accept) begin
      sw_stable_next = sw_sync_reg;
    end else begin
      sw_cnt_next = sw_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    btn_differs     = (btn_sync_reg != btn_stable_reg);
    btn_accept      = btn_differs && (btn_cnt_reg == DB_LAST);
    // The button value only differs when it changes, so accepting a 1 is
    // exactly the rising edge of the debounced button.
    btn_press       = btn_accept && btn_sync_reg;
    btn_stable_next = btn_stable_reg;
    btn_cnt_next    = btn_cnt_reg;
    if (!btn_differs) begin
      btn_cnt_next = '0;
    end else if (btn_accept) begin
      btn_stable_next = btn_sync_reg;
    end else begin
      btn_cnt_next = btn_cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // CPU register writes and the sticky press flag
  // ---------------------------------------------------------------------------
  always_comb begin
    led_next     = led_reg;
    seg_next     = seg_reg;
    pending_next = pending_reg;
    if (IoWrite) begin
      case (io_sel)
        SEL_LED: led_next = io_wdata[15:0];
        SEL_SEG: seg_next = io_wdata;
        default: ;  // SW and BTN are read-only
      endcase
    end
    // A press landing in the same cycle as a clearing read must not be lost.
    if (btn_press) begin
      pending_next = 1'b1;
    end else if (IoRead && (io_sel == SEL_BTN)) begin
      pending_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  always_comb begin
    presc_next = presc_reg;
    digit_next = digit_reg;
    if (presc_reg == SCAN_LAST) begin
      presc_next = '0;
      digit_next = digit_reg + 3'd1;  // 7 wraps to 0 naturally
    end else begin
      presc_next = presc_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg        <= '0;
      seg_reg        <= '0;
      pending_reg    <= 1'b0;
      sw_meta_reg    <= '0;
      sw_sync_reg    <= '0;
      sw_stable_reg  <= '0;
      sw_cnt_reg     <= '0;
      btn_meta_reg   <= 1'b0;
      btn_sync_reg   <= 1'b0;
      btn_stable_reg <= 1'b0;
      btn_cnt_reg    <= '0;
      presc_reg      <= '0;
      digit_reg      <= '0;
    end else begin
      led_reg        <= led_next;
      seg_reg        <= seg_next;
      pending_reg    <= pending_next;
      sw_meta_reg    <= sw_in;
      sw_sync_reg    <= sw_meta_reg;
      sw_stable_reg  <= sw_stable_next;
      sw_cnt_reg     <= sw_cnt_next;
      btn_meta_reg   <= btn_in;
      btn_sync_reg   <= btn_meta_reg;
      btn_stable_reg <= btn_stable_next;
      btn_cnt_reg    <= btn_cnt_next;
      presc_reg      <= presc_next;
      digit_reg      <= digit_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Load path: purely combinational, so a single-cycle load sees the
  // register value from before the edge, even during a simultaneous store.
  // ---------------------------------------------------------------------------
  always_comb begin
    io_rdata = '0;
    if (IoRead) begin
      case (io_sel)
        SEL_SW:  io_rdata = {16'h0000, sw_stable_reg};
        SEL_LED: io_rdata = {16'h0000, led_reg};
        SEL_SEG: io_rdata = seg_reg;
        SEL_BTN: io_rdata = {31'd0, pending_reg};
        default: io_rdata = '0;
      endcase
    end
  end

  assign led_out = led_reg;

  // ---------------------------------------------------------------------------
  // Display drive
  // ---------------------------------------------------------------------------
  logic [3:0] seg_nibble [8];
  logic [3:0] cur_nibble;

  for (genvar gi = 0; gi < 8; gi++) begin : g_digit
    assign seg_nibble[gi] = seg_reg[4*gi +: 4];
    assign seg_an[gi]     = (digit_reg != 3'(gi));
  end

  assign cur_nibble = seg_nibble[digit_reg];

  // Active-low glyphs; bit 7 (decimal point) is always held off.
  always_comb begin
    seg_out = 8'hFF;
    case (cur_nibble)
      4'h0: seg_out = 8'hC0;
      4'h1: seg_out = 8'hF9;
      4'h2: seg_out = 8'hA4;
      4'h3: seg_out = 8'hB0;
      4'h4: seg_out = 8'h99;
      4'h5: seg_out = 8'h92;
      4'h6: seg_out = 8'h82;
      4'h7: seg_out = 8'hF8;
      4'h8: seg_out = 8'h80;
      4'h9: seg_out = 8'h90;
      4'hA: seg_out = 8'h88;
      4'hB: seg_out = 8'h83;
      4'hC: seg_out = 8'hC6;
      4'hD: seg_out = 8'hA1;
      4'hE: seg_out = 8'h86;
      4'hF: seg_out = 8'h8E;
      default: seg_out = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_io_responder.sv
// -----------------------------------------------------------------------------
// tb_io_responder
// Directed testbench for io_responder, run with DEBOUNCE_CYCLES=4 and
// SCAN_DIV=2. Inputs change at posedge+1. Outputs are sampled before the
// next rising edge.
// -----------------------------------------------------------------------------
module tb_io_responder;

  localparam int DEBOUNCE_CYCLES = 4;
  localparam int SCAN_DIV        = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        IoRead;
  logic        IoWrite;
  logic [1:0]  io_sel;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic [15:0] sw_in;
  logic        btn_in;
  logic [15:0] led_out;
  logic [7:0]  seg_an;
  logic [7:0]  seg_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  io_responder #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SCAN_DIV       (SCAN_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .IoRead  (IoRead),
    .IoWrite (IoWrite),
    .io_sel  (io_sel),
    .io_wdata(io_wdata),
    .io_rdata(io_rdata),
    .sw_in   (sw_in),
    .btn_in  (btn_in),
    .led_out (led_out),
    .seg_an  (seg_an),
    .seg_out (seg_out)
  );

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance n rising edges, leaving time at posedge+1.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] sel, input logic [31:0] data);
    io_sel   = sel;
    io_wdata = data;
    IoWrite  = 1'b1;
    step(1);
    IoWrite  = 1'b0;
  endtask

  // Single-cycle load: sample in-cycle, then let the edge pass with IoRead high.
  task automatic read_check(input string tag, input logic [1:0] sel,
                            input logic [31:0] exp);
    io_sel = sel;
    IoRead = 1'b1;
    #1;
    check_value(tag, io_rdata, exp);
    step(1);
    IoRead = 1'b0;
  endtask

  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      default: return 8'hFF;
    endcase
  endfunction

  initial begin
    logic [7:0] one_hot;
    int         idx;
    int         waited;

    rst      = 1'b1;
    IoRead   = 1'b0;
    IoWrite  = 1'b0;
    io_sel   = 2'd0;
    io_wdata = 32'h0;
    sw_in    = 16'h0000;
    btn_in   = 1'b0;
    step(2);
    rst = 1'b0;

    // Reset state
    #1;
    check_value("rst_led",     {16'h0, led_out}, 32'h0);
    check_value("rst_seg_an",  {24'h0, seg_an},  32'hFE);
    check_value("rst_seg_out", {24'h0, seg_out}, 32'hC0);
    check_value("rst_rdata",   io_rdata,         32'h0);

    // LED write/read
    write_reg(2'd1, 32'h1234ABCD);
    check_value("led_out_after_wr", {16'h0, led_out}, 32'h0000ABCD);
    read_check("led_read", 2'd1, 32'h0000ABCD);

    // Writes to read-only registers are ignored
    write_reg(2'd0, 32'hFFFFFFFF);
    read_check("sw_ro", 2'd0, 32'h0);
    write_reg(2'd3, 32'hFFFFFFFF);
    read_check("btn_ro", 2'd3, 32'h0);
    check_value("led_unchanged", {16'h0, led_out}, 32'h0000ABCD);

    // Simultaneous load and store on SEG
    write_reg(2'd2, 32'h11);
    io_sel   = 2'd2;
    io_wdata = 32'h22;
    IoRead   = 1'b1;
    IoWrite  = 1'b1;
    #1;
    check_value("rw_old", io_rdata, 32'h11);
    step(1);
    IoWrite = 1'b0;
    #1;
    check_value("rw_new", io_rdata, 32'h22);
    IoRead = 1'b0;
    #1;
    check_value("rdata_idle", io_rdata, 32'h0);

    // Display scan: align on the 7F -> FE transition, then follow 18 cycles
    write_reg(2'd2, 32'h76543210);
    waited = 0;
    while (seg_an !== 8'h7F && waited < 40) begin
      step(1);
      waited++;
    end
    waited = 0;
    while (seg_an !== 8'hFE && waited < 40) begin
      step(1);
      waited++;
    end
    check_value("scan_sync", {24'h0, seg_an}, 32'hFE);
    one_hot = 8'h01;
    for (int i = 0; i < 18; i++) begin
      idx = (i / 2) % 8;
      check_value($sformatf("scan_an_%0d", i), {24'h0, seg_an},
                  {24'h0, ~(one_hot << idx)});
      check_value($sformatf("scan_seg_%0d", i), {24'h0, seg_out},
                  {24'h0, glyph(idx)});
      step(1);
    end

    // Switch debounce: 2 sync + 4 debounce cycles
    sw_in = 16'h5A5A;
    step(5);
    read_check("sw_early", 2'd0, 32'h0);
    read_check("sw_accept", 2'd0, 32'h5A5A);

    // Two-cycle glitch is never visible
    sw_in = 16'hFFFF;
    step(2);
    sw_in = 16'h5A5A;
    for (int i = 0; i < 8; i++) begin
      read_check($sformatf("sw_glitch_%0d", i), 2'd0, 32'h5A5A);
    end

    // Reset mid-debounce with LED full on. The store in the reset cycle must lose.
    write_reg(2'd1, 32'h0000FFFF);
    check_value("led_ffff", {16'h0, led_out}, 32'hFFFF);
    sw_in = 16'h0F0F;
    step(3);
    rst      = 1'b1;
    IoWrite  = 1'b1;
    io_sel   = 2'd1;
    io_wdata = 32'h00001234;
    step(1);
    rst     = 1'b0;
    IoWrite = 1'b0;
    #1;
    check_value("led_after_rst", {16'h0, led_out}, 32'h0);
    check_value("seg_an_after_rst", {24'h0, seg_an}, 32'hFE);
    check_value("seg_out_after_rst", {24'h0, seg_out}, 32'hC0);
    io_sel = 2'd0;
    IoRead = 1'b1;
    #1;
    check_value("sw_after_rst", io_rdata, 32'h0);
    IoRead = 1'b0;
    step(5);
    read_check("sw_rst_early", 2'd0, 32'h0);
    read_check("sw_rst_accept", 2'd0, 32'h0F0F);

    // Clean button press, then the clearing read
    btn_in = 1'b1;
    step(6);
    read_check("btn_press", 2'd3, 32'h1);
    read_check("btn_cleared", 2'd3, 32'h0);
    btn_in = 1'b0;
    step(8);
    read_check("btn_release", 2'd3, 32'h0);

    // Press lands in the clearing read cycle: press wins
    btn_in = 1'b1;
    step(5);
    read_check("btn_race_read", 2'd3, 32'h0);
    read_check("btn_race_after", 2'd3, 32'h1);
    read_check("btn_race_clear", 2'd3, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
